operand_bypass_unit: RTL
========================

// Module: operand_bypass_unit
// PURPOSE
//  Parametrised forwarding unit; successor to the single fixed-width 2:1 bypass select.
//  Tracks the last DEPTH in-flight register writes in a shift history (entry 0 = youngest).
//  Resolves NUM_SRC read operands against that history; youngest match wins, else register-file data.
//  Raises a per-source stall when the youngest match has no data yet (load in flight).
//  Sits between decode/RF read and the ALU operand inputs.
// PARAMETERS
//  DATA_W    16  operand/result width
//  REG_AW    4   register address width; register 0 reads as zero, is never forwarded
//  NUM_SRC   2   number of operand lookup ports
//  DEPTH     3   history entries (EX, MEM, WB); >= 2
//  FILL_IDX  1   entry index that accepts late data on the fill port; < DEPTH
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               async active-low reset
//  adv          in   1               pipeline advance: history shifts by one
//  flush        in   1               clear all history entries
//  iss_we       in   1               issuing instruction writes a register
//  iss_rd       in   REG_AW          its destination register
//  iss_data     in   DATA_W          its result, if already known
//  iss_dvld     in   1               iss_data valid (0 for loads)
//  fill_vld     in   1               late result for entry FILL_IDX
//  fill_data    in   DATA_W          late result value
//  src_addr     in   NUM_SRC*REG_AW  packed operand register addresses
//  src_rf_data  in   NUM_SRC*DATA_W  packed register-file read data
//  src_data     out  NUM_SRC*DATA_W  packed resolved operands
//  src_stall    out  NUM_SRC         per-source not-ready
//  stall_o      out  1               OR of src_stall
// BEHAVIOUR
//  - Entry fields: we, rd, data, dvld. Reset/flush: all we=0, dvld=0, data=0 -> stall_o=0,
//    src_data=src_rf_data. Reset is async; flush is synchronous and beats adv and fill.
//  - adv=1: entry[i+1]<=entry[i]; entry[0]<=issue fields (we forced 0 if iss_rd==0); the
//    oldest entry is dropped (the register file is write-through, so its value is in src_rf_data).
//    Caller drives iss_we=0 on a bubble. adv=0: history holds.
//  - Fill: fill_vld with entry[FILL_IDX].we=1 and dvld=0 sets its data and dvld=1. With adv=1 in the same
//    cycle, the fill lands in entry[FILL_IDX+1] (dropped if FILL_IDX==DEPTH-1). Ignored otherwise.
//  - Lookup (combinational, per source s): ignore if src_addr==0 (src_data=0, no stall).
//    Scan entries 0..DEPTH-1; first with we=1 and rd==src_addr is the match.
//    Match dvld=1 -> src_data=match data. Match is FILL_IDX, dvld=0, fill_vld=1 -> src_data=fill_data
//    (same-cycle fill bypass), no stall. Otherwise match dvld=0 -> src_data=0, src_stall[s]=1.
//    No match -> src_data=src_rf_data slice.
//  - Lookup latency 0 cycles; history update 1 cycle. Older matches never override a younger
//    pending entry (stall, not stale data).
//  - Caller holds issue on stall_o and drives adv=1, iss_we=0 to insert a bubble.
// CONFIGURATION
//  BYPASS_STATS_EN defined: adds outputs fwd_cnt[15:0], stall_cnt[15:0], saturating at 16'hFFFF,
//   reset 0 (not cleared by flush). fwd_cnt increments by 1 per cycle in which any source is
//   forwarded from history; stall_cnt increments by 1 per cycle with stall_o=1.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package: DATA_W/REG_AW defaults, history-entry struct {we, rd, data, dvld}, ZERO_REG const.
//  One sub-module: bypass_lookup (one source: addr + history + fill -> data, stall), instantiated
//  NUM_SRC times via generate; history shift register and stats counters in top.
// TESTING
//  1 Reset: rst_n=0 mid-run with pending load -> stall_o=0 at once, src_data=src_rf_data.
//  2 Issue we rd=3 data=16'h00AA dvld=1, adv=1; next cycle src_addr=3 -> src_data=16'h00AA, no stall.
//  3 Issue rd=5 data=16'h1111, then rd=5 data=16'h2222 -> src_addr=5 returns 16'h2222 (youngest wins).
//  4 Load rd=4 dvld=0, advance to FILL_IDX -> src_addr=4 stalls; fill_vld=1 data=16'hBEEF same cycle
//    -> src_data=16'hBEEF, no stall; next cycle still 16'hBEEF from entry.
//  5 Issue rd=0 data=16'hFFFF -> src_addr=0 reads 0; flush with adv=1 -> history empty, rf data passes.
//  6 Push rd=7 then DEPTH bubbles -> src_addr=7 returns src_rf_data; with BYPASS_STATS_EN counters match.

Source files
------------

// File: rtl/operand_bypass_unit_pkg.sv
// Shared types and defaults for the operand bypass unit: the history-entry layout and
// the hard-wired zero register.
package operand_bypass_unit_pkg;

   localparam int BYP_DATA_W = 16;
   localparam int BYP_REG_AW = 4;

   localparam logic [BYP_REG_AW-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                  we;
      logic [BYP_REG_AW-1:0] rd;
      logic [BYP_DATA_W-1:0] data;
      logic                  dvld;
   } hist_entry_t;

endpackage

// File: rtl/bypass_lookup.sv
// Resolves one read operand against the write history: the youngest matching entry wins,
// a pending match stalls unless its late result arrives on the fill port this cycle.
module bypass_lookup
   import operand_bypass_unit_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int FILL_IDX = 1
) (
   input  logic [BYP_REG_AW-1:0] i_addr,
   input  logic [BYP_DATA_W-1:0] i_rf_data,
   input  hist_entry_t [DEPTH-1:0] i_hist,
   input  logic                  i_fill_vld,
   input  logic [BYP_DATA_W-1:0] i_fill_data,
   output logic [BYP_DATA_W-1:0] o_data,
   output logic                  o_stall,
   output logic                  o_fwd
);

   logic        w_hit;
   logic        w_sel_fill;
   hist_entry_t w_sel;

   // NOTE: every signal written here gets a default first, otherwise a path that skips
   // the assignment makes synthesis infer a latch.
   always_comb begin
      w_hit      = 1'b0;
      w_sel_fill = 1'b0;
      w_sel      = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_hist[i].we && (i_hist[i].rd == i_addr)) begin
            w_hit      = 1'b1;
            w_sel      = i_hist[i];
            w_sel_fill = (i == FILL_IDX);
         end
      end

      o_data  = i_rf_data;
      o_stall = 1'b0;
      o_fwd   = 1'b0;
      if (i_addr == ZERO_REG) begin
         o_data = '0;
      end else if (w_hit) begin
         if (w_sel.dvld) begin
            o_data = w_sel.data;
            o_fwd  = 1'b1;
         end else if (w_sel_fill && i_fill_vld) begin
            o_data = i_fill_data;
            o_fwd  = 1'b1;
         end else begin
            o_data  = '0;
            o_stall = 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_bypass_unit.sv
// Parametrised operand forwarding unit: DEPTH-entry write history plus NUM_SRC lookups.
// Optional BYPASS_STATS_EN adds saturating forward/stall event counters.
module operand_bypass_unit
   import operand_bypass_unit_pkg::*;
#(
   parameter int DATA_W   = BYP_DATA_W,
   parameter int REG_AW   = BYP_REG_AW,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int FILL_IDX = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      adv,
   input  logic                      flush,
   input  logic                      iss_we,
   input  logic [REG_AW-1:0]         iss_rd,
   input  logic [DATA_W-1:0]         iss_data,
   input  logic                      iss_dvld,
   input  logic                      fill_vld,
   input  logic [DATA_W-1:0]         fill_data,
   input  logic [NUM_SRC*REG_AW-1:0] src_addr,
   input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
   output logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_stall,
   output logic                      stall_o
`ifdef BYPASS_STATS_EN
   ,
   output logic [15:0]               fwd_cnt,
   output logic [15:0]               stall_cnt
`endif
);

   hist_entry_t [DEPTH-1:0] r_hist;
   hist_entry_t [DEPTH-1:0] w_filled;
   hist_entry_t [DEPTH-1:0] w_hist_nxt;
   hist_entry_t             w_new;
   logic                    w_fill_ok;
   logic [NUM_SRC-1:0]      w_fwd;

   // Fill is applied before the shift, so with adv it lands one entry older (or falls off).
   always_comb begin
      w_fill_ok  = fill_vld && r_hist[FILL_IDX].we && !r_hist[FILL_IDX].dvld;
      w_new.we   = iss_we && (iss_rd != ZERO_REG);
      w_new.rd   = iss_rd;
      w_new.data = iss_data;
      w_new.dvld = iss_dvld;
      w_filled   = r_hist;
      if (w_fill_ok) begin
         w_filled[FILL_IDX].data = fill_data;
         w_filled[FILL_IDX].dvld = 1'b1;
      end
      w_hist_nxt = adv ? {w_filled[DEPTH-2:0], w_new} : w_filled;
   end

   // NOTE: the history is a handful of flops, not a RAM, so it is reset; sequential state
   // is written with <= so every entry samples the pre-edge values of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist <= '0;
      end else if (flush) begin
         r_hist <= '0;
      end else begin
         r_hist <= w_hist_nxt;
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      bypass_lookup #(
         .DEPTH    (DEPTH),
         .FILL_IDX (FILL_IDX)
      ) u_lookup (
         .i_addr      (src_addr[s*REG_AW +: REG_AW]),
         .i_rf_data   (src_rf_data[s*DATA_W +: DATA_W]),
         .i_hist      (r_hist),
         .i_fill_vld  (fill_vld),
         .i_fill_data (fill_data),
         .o_data      (src_data[s*DATA_W +: DATA_W]),
         .o_stall     (src_stall[s]),
         .o_fwd       (w_fwd[s])
      );
   end

   assign stall_o = |src_stall;

`ifdef BYPASS_STATS_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (|w_fwd && (fwd_cnt != 16'hFFFF)) begin
            fwd_cnt <= fwd_cnt + 16'd1;
         end
         if (stall_o && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = |w_fwd;
`endif

endmodule
